// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-entry sample buffer feeding a clk-divided bit clock
// with MSB-first left/right slots; WS leads the first data bit of each slot by one BCK.
module i2s_tx #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int BCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                enable,
  input  logic                mute,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                i2s_bck,
  output logic                i2s_ws,
  output logic                i2s_d0,
  output logic                frame_strobe,
  output logic [7:0]          underflow_cnt
);

  localparam int DIV_W  = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int BIDX_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCK_DIV - 1);
  localparam logic [BIDX_W-1:0] LAST_IDX   = BIDX_W'(2 * SLOT_W - 1);
  localparam logic [BIDX_W-1:0] SLOT_IDX   = BIDX_W'(SLOT_W);
  localparam logic [BIDX_W-1:0] SAMPLE_IDX = BIDX_W'(SAMPLE_W);

  // Serial bit at frame index idx: MSB-first per slot, zero padding past SAMPLE_W.
  function automatic logic pcm_bit(
    input logic [SAMPLE_W-1:0] left,
    input logic [SAMPLE_W-1:0] right,
    input logic [BIDX_W-1:0]   idx
  );
    logic [BIDX_W-1:0]   pos;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] shifted;
    if (idx >= SLOT_IDX) begin
      pos  = idx - SLOT_IDX;
      word = right;
    end else begin
      pos  = idx;
      word = left;
    end
    if (pos < SAMPLE_IDX) begin
      shifted = word >> (SAMPLE_IDX - BIDX_W'(1) - pos);
      pcm_bit = shifted[0];
    end else begin
      shifted = {SAMPLE_W{1'b0}};
      pcm_bit = 1'b0;
    end
  endfunction

  // WS is high one BCK ahead of the right slot and drops one BCK ahead of the next left slot.
  function automatic logic slot_ws(input logic [BIDX_W-1:0] idx);
    slot_ws = (idx >= (SLOT_IDX - BIDX_W'(1))) && (idx != LAST_IDX);
  endfunction

  logic [DIV_W-1:0]    div_cnt_r;
  logic [BIDX_W-1:0]   b_r;
  logic                bck_r;
  logic                ws_r;
  logic                d0_r;
  logic                strobe_r;
  logic [7:0]          uf_cnt_r;
  logic                hold_full_r;
  logic [SAMPLE_W-1:0] hold_l_r;
  logic [SAMPLE_W-1:0] hold_r_r;
  logic [SAMPLE_W-1:0] sh_l_r;
  logic [SAMPLE_W-1:0] sh_r_r;

  logic                wrap_s;
  logic                fall_s;
  logic                load_s;
  logic                accept_s;
  logic                bypass_s;
  logic                underflow_s;
  logic [BIDX_W-1:0]   b_next_s;
  logic [SAMPLE_W-1:0] load_l_s;
  logic [SAMPLE_W-1:0] load_r_s;
  logic [SAMPLE_W-1:0] frame_l_s;
  logic [SAMPLE_W-1:0] frame_r_s;
  logic                ws_next_s;
  logic                d0_next_s;

  // Divider events, frame-load source selection and next serial outputs.
  always_comb begin
    wrap_s      = enable && (div_cnt_r == DIV_LAST);
    fall_s      = wrap_s && bck_r;
    load_s      = fall_s && (b_r == LAST_IDX);
    accept_s    = s_valid && !hold_full_r;
    bypass_s    = load_s && accept_s;
    underflow_s = load_s && !hold_full_r && !s_valid;
    if (b_r == LAST_IDX) begin
      b_next_s = {BIDX_W{1'b0}};
    end else begin
      b_next_s = b_r + BIDX_W'(1);
    end
    if (mute || underflow_s) begin
      load_l_s = {SAMPLE_W{1'b0}};
      load_r_s = {SAMPLE_W{1'b0}};
    end else if (hold_full_r) begin
      load_l_s = hold_l_r;
      load_r_s = hold_r_r;
    end else begin
      load_l_s = s_left;
      load_r_s = s_right;
    end
    if (load_s) begin
      frame_l_s = load_l_s;
      frame_r_s = load_r_s;
    end else begin
      frame_l_s = sh_l_r;
      frame_r_s = sh_r_r;
    end
    ws_next_s = slot_ws(b_next_s);
    d0_next_s = pcm_bit(frame_l_s, frame_r_s, b_next_s);
  end

  // Bit clock, bit index and registered I2S pins; disabling drops the frame in progress.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_cnt_r <= {DIV_W{1'b0}};
      b_r       <= LAST_IDX;
      bck_r     <= 1'b0;
      ws_r      <= 1'b0;
      d0_r      <= 1'b0;
      strobe_r  <= 1'b0;
      sh_l_r    <= {SAMPLE_W{1'b0}};
      sh_r_r    <= {SAMPLE_W{1'b0}};
    end else if (!enable) begin
      div_cnt_r <= {DIV_W{1'b0}};
      b_r       <= LAST_IDX;
      bck_r     <= 1'b0;
      ws_r      <= 1'b0;
      d0_r      <= 1'b0;
      strobe_r  <= 1'b0;
    end else begin
      div_cnt_r <= wrap_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));
      if (wrap_s) begin
        bck_r <= !bck_r;
      end
      if (fall_s) begin
        b_r  <= b_next_s;
        ws_r <= ws_next_s;
        d0_r <= d0_next_s;
      end
      if (load_s) begin
        sh_l_r <= load_l_s;
        sh_r_r <= load_r_s;
      end
      strobe_r <= load_s;
    end
  end

  // One-entry holding buffer; a pair offered in the load cycle bypasses it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_full_r <= 1'b0;
      hold_l_r    <= {SAMPLE_W{1'b0}};
      hold_r_r    <= {SAMPLE_W{1'b0}};
    end else if (load_s && hold_full_r) begin
      hold_full_r <= 1'b0;
    end else if (accept_s && !bypass_s) begin
      hold_full_r <= 1'b1;
      hold_l_r    <= s_left;
      hold_r_r    <= s_right;
    end
  end

  // Saturating count of frames that started with no sample available.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      uf_cnt_r <= 8'd0;
    end else if (underflow_s && (uf_cnt_r != 8'hFF)) begin
      uf_cnt_r <= uf_cnt_r + 8'd1;
    end
  end

  assign s_ready       = !hold_full_r;
  assign i2s_bck       = bck_r;
  assign i2s_ws        = ws_r;
  assign i2s_d0        = d0_r;
  assign frame_strobe  = strobe_r;
  assign underflow_cnt = uf_cnt_r;

endmodule
